// File: rtl/prog_sequencer.sv
// Instruction-feed stage for the 9-bit processor: program RAM, Run/Done
// handshake, MVI immediate supply, HALT detection and protocol timeouts.
module prog_sequencer #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic [ADDR_W:0]   ProgLen,
    input  logic              LdEn,
    input  logic [ADDR_W-1:0] LdAddr,
    input  logic [8:0]        LdData,
    input  logic              Done,
    output logic [8:0]        DIN,
    output logic              Run,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Halted,
    output logic              Error
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + SETUP_CYC + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_SETUP,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_HOLD,
        S_HALT,
        S_ERR
    } state_t;

    state_t            r_state;
    logic [8:0]        r_mem [DEPTH];
    logic [8:0]        r_din;
    logic              r_run;
    logic [ADDR_W:0]   r_pc;
    logic [ADDR_W:0]   r_len;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_halted;
    logic              r_error;
    logic              r_mvi;

    logic [ADDR_W:0]   w_pc_inc;
    logic [ADDR_W:0]   w_pc_inc2;
    logic [8:0]        w_rd_pc;
    logic [8:0]        w_rd_imm;
    logic              w_is_halt;
    logic              w_is_mvi;
    logic              w_tout;

    // PC is kept one bit wider than the address so end-of-program compares never wrap
    assign w_pc_inc  = r_pc + (ADDR_W+1)'(1);
    assign w_pc_inc2 = r_pc + (ADDR_W+1)'(2);
    assign w_rd_pc   = r_mem[r_pc[ADDR_W-1:0]];
    assign w_rd_imm  = r_mem[w_pc_inc[ADDR_W-1:0]];
    assign w_is_halt = r_din[8];
    assign w_is_mvi  = (r_din[8:6] == 3'b001);
    assign w_tout    = (r_cnt == CNT_W'(TIMEOUT - 1));

    assign DIN    = r_din;
    assign Run    = r_run;
    assign PC     = r_pc[ADDR_W-1:0];
    assign Busy   = r_busy;
    assign Halted = r_halted;
    assign Error  = r_error;

    // Program RAM: contents survive reset; loads are locked out while running
    always_ff @(posedge Clock) begin
        if (LdEn && !r_busy) begin
            r_mem[LdAddr] <= LdData;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state  <= S_IDLE;
            r_din    <= '0;
            r_run    <= 1'b0;
            r_pc     <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
            r_error  <= 1'b0;
            r_mvi    <= 1'b0;
        end else begin
            r_run <= 1'b0;
            case (r_state)
                S_IDLE, S_HALT, S_ERR: begin
                    if (Start) begin
                        r_state  <= S_CHECK;
                        r_pc     <= '0;
                        r_len    <= ProgLen;
                        r_busy   <= 1'b1;
                        r_halted <= 1'b0;
                        r_error  <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (r_pc >= r_len) begin
                        r_state  <= S_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_din   <= w_rd_pc;
                        r_cnt   <= '0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == CNT_W'(SETUP_CYC - 1)) begin
                        if (w_is_halt) begin
                            r_state  <= S_HALT;
                            r_busy   <= 1'b0;
                            r_halted <= 1'b1;
                        end else if (w_is_mvi && (w_pc_inc >= r_len)) begin
                            r_state <= S_ERR;
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                        end else begin
                            r_run   <= 1'b1;
                            r_mvi   <= w_is_mvi;
                            r_state <= S_ISSUE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_ISSUE: begin
                    // DIN carries the opcode word no longer once the immediate is presented
                    if (r_mvi) begin
                        r_din <= w_rd_imm;
                    end
                    r_cnt   <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!Done) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_DONE;
                    end else if (w_tout) begin
                        r_state <= S_ERR;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (Done) begin
                        r_state <= S_HOLD;
                    end else if (w_tout) begin
                        r_state <= S_ERR;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    r_pc    <= r_mvi ? w_pc_inc2 : w_pc_inc;
                    r_state <= S_CHECK;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomized self-checking bench for prog_sequencer against a program-level reference model.
module tb_prog_sequencer;

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned SETUP_CYC = 2;
    localparam int unsigned TIMEOUT   = 15;
    localparam int          DEPTH     = 32;

    logic              Clock;
    logic              Resetn;
    logic              Start;
    logic [ADDR_W:0]   ProgLen;
    logic              LdEn;
    logic [ADDR_W-1:0] LdAddr;
    logic [8:0]        LdData;
    logic              Done;
    logic [8:0]        DIN;
    logic              Run;
    logic [ADDR_W-1:0] PC;
    logic              Busy;
    logic              Halted;
    logic              Error;

    prog_sequencer #(.ADDR_W(ADDR_W), .SETUP_CYC(SETUP_CYC), .TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .ProgLen(ProgLen),
        .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData), .Done(Done),
        .DIN(DIN), .Run(Run), .PC(PC), .Busy(Busy), .Halted(Halted), .Error(Error)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [8:0] tb_mem [DEPTH];
    logic [8:0] exp_din_last = '0;

    // processor model knobs: Done drops p_drop cycles after Run, stays low p_low cycles
    int p_drop = 1;
    int p_low  = 1;
    int done_rise_cyc = 0;
    bit rise_valid = 0;

    // observed pulses
    int q_pc[$];
    int q_din[$];
    int q_din2[$];
    int run_bad = 0;
    int min_gap = 1000;
    int last_run_cyc = 0;

    // expected pulses
    int e_pc[$];
    int e_din[$];
    int e_din2[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    always @(posedge Clock) cyc <= cyc + 1;

    // Processor: responds to each Run pulse with a Done low window
    initial begin
        Done = 1'b1;
        forever begin
            @(negedge Clock);
            if (Resetn && Run === 1'b1 && p_drop < 50) begin
                repeat (p_drop) @(negedge Clock);
                Done = 1'b0;
                repeat (p_low) @(negedge Clock);
                Done = 1'b1;
                done_rise_cyc = cyc;
                rise_valid = 1;
            end
        end
    end

    // Monitor: records every Run pulse, DIN during and after it, and pacing
    initial begin
        bit cap;
        bit prev_run;
        cap = 0;
        prev_run = 0;
        forever begin
            @(negedge Clock);
            if (cap) begin
                q_din2.push_back(int'(DIN));
                cap = 0;
            end
            if (Run === 1'b1) begin
                q_pc.push_back(int'(PC));
                q_din.push_back(int'(DIN));
                cap = 1;
                last_run_cyc = cyc;
                if (prev_run || Busy !== 1'b1) run_bad++;
                if (rise_valid && (cyc - done_rise_cyc) < min_gap) min_gap = cyc - done_rise_cyc;
            end
            prev_run = (Run === 1'b1);
        end
    end

    task automatic load(input int addr, input logic [8:0] data);
        @(negedge Clock);
        LdEn = 1'b1;
        LdAddr = ADDR_W'(addr);
        LdData = data;
        tb_mem[addr] = data;
        @(negedge Clock);
        LdEn = 1'b0;
    endtask

    // ld_mode: 0 none, 1 write mem[0] together with Start, 2 attempt a write while busy
    task automatic run_prog(input string tag, input int len, input int d, input int lo,
                            input int ld_mode, input logic [8:0] ld_data);
        int pc;
        logic [8:0] w;
        logic [8:0] nxt;
        bit mvi;
        bit e_err;
        bit e_halt;
        bit tout;
        bit fin;
        int end_cyc;
        int n;

        if (ld_mode == 1) tb_mem[0] = ld_data;
        e_pc.delete(); e_din.delete(); e_din2.delete();
        e_err = 0; e_halt = 0; tout = 0; pc = 0;
        while (1) begin
            if (pc >= len) begin e_halt = 1; break; end
            w = tb_mem[pc];
            if (w[8]) begin e_halt = 1; exp_din_last = w; break; end
            mvi = (w[8:6] == 3'b001);
            if (mvi && pc + 1 >= len) begin e_err = 1; exp_din_last = w; break; end
            e_pc.push_back(pc);
            e_din.push_back(int'(w));
            nxt = mvi ? tb_mem[pc + 1] : w;
            e_din2.push_back(int'(nxt));
            exp_din_last = nxt;
            if (d > int'(TIMEOUT) || lo > int'(TIMEOUT)) begin e_err = 1; tout = 1; break; end
            pc += mvi ? 2 : 1;
        end

        q_pc.delete(); q_din.delete(); q_din2.delete();
        run_bad = 0; min_gap = 1000; rise_valid = 0;
        p_drop = d; p_low = lo;

        @(negedge Clock);
        ProgLen = (ADDR_W+1)'(len);
        Start = 1'b1;
        if (ld_mode == 1) begin LdEn = 1'b1; LdAddr = '0; LdData = ld_data; end
        @(negedge Clock);
        Start = 1'b0;
        LdEn = 1'b0;
        check({tag, " busy_on_start"}, 32'(Busy), 1);
        check({tag, " halted_cleared"}, 32'(Halted), 0);
        check({tag, " error_cleared"}, 32'(Error), 0);
        if (ld_mode == 2) begin
            @(negedge Clock);
            LdEn = 1'b1; LdAddr = '0; LdData = 9'h1ff;
            @(negedge Clock);
            LdEn = 1'b0;
        end

        fin = 0;
        for (int i = 0; i < 3000 && !fin; i++) begin
            if (Busy !== 1'b1) fin = 1;
            else @(negedge Clock);
        end
        end_cyc = cyc;
        check({tag, " finished"}, 32'(fin), 1);

        check({tag, " run_count"}, 32'(q_pc.size()), 32'(e_pc.size()));
        n = (q_pc.size() < e_pc.size()) ? q_pc.size() : e_pc.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s pc[%0d]", tag, i), 32'(q_pc[i]), 32'(e_pc[i]));
            check($sformatf("%s din[%0d]", tag, i), 32'(q_din[i]), 32'(e_din[i]));
            if (i < q_din2.size())
                check($sformatf("%s din_after[%0d]", tag, i), 32'(q_din2[i]), 32'(e_din2[i]));
        end
        check({tag, " run_proto"}, 32'(run_bad), 0);
        check({tag, " halted"}, 32'(Halted), 32'(e_halt));
        check({tag, " error"}, 32'(Error), 32'(e_err));
        check({tag, " busy_end"}, 32'(Busy), 0);
        check({tag, " final_pc"}, 32'(PC), 32'(pc % DEPTH));
        check({tag, " final_din"}, 32'(DIN), 32'(exp_din_last));
        if (e_pc.size() >= 2)
            check({tag, " pacing"}, 32'(min_gap >= int'(SETUP_CYC) + 1), 1);
        if (tout && d >= 50)
            check({tag, " timeout_cycles"}, 32'(end_cyc - last_run_cyc), 32'(TIMEOUT + 1));
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        logic [8:0] w;
        int len;

        Resetn = 1'b1; Start = 1'b0; ProgLen = '0;
        LdEn = 1'b0; LdAddr = '0; LdData = '0;
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = '0;
        #2 Resetn = 1'b0;
        repeat (3) @(negedge Clock);
        check("reset din", 32'(DIN), 0);
        check("reset run", 32'(Run), 0);
        check("reset pc", 32'(PC), 0);
        check("reset busy", 32'(Busy), 0);
        check("reset halted", 32'(Halted), 0);
        check("reset error", 32'(Error), 0);
        Resetn = 1'b1;
        for (int i = 0; i < DEPTH; i++) load(i, 9'h000);

        // MVI R0,#5 ; MV R1,R0 ; HALT
        load(0, 9'b001000000); load(1, 9'b000000101);
        load(2, 9'b000001000); load(3, 9'b100000000);
        run_prog("simple", 4, 1, 1, 0, '0);

        load(0, 9'b010000001); load(1, 9'b011000001);
        run_prog("addsub", 2, 1, 3, 0, '0);

        load(0, 9'b000001010);
        run_prog("timeout", 1, 99, 1, 0, '0);

        load(0, 9'b001011000);
        run_prog("trunc_mvi", 1, 1, 1, 0, '0);

        load(0, 9'b001000000); load(1, 9'b000000101);
        load(2, 9'b000001000); load(3, 9'b100000000);
        run_prog("ld_busy", 4, 1, 1, 2, '0);
        run_prog("ld_rerun", 4, 1, 1, 0, '0);

        run_prog("len0", 0, 1, 1, 0, '0);

        run_prog("start_ld", 4, 1, 1, 1, 9'b100000000);
        run_prog("start_ld2", 4, 2, 2, 1, 9'b001000000);

        load(0, 9'b010001010);
        run_prog("edge_ok", 1, 15, 15, 0, '0);
        run_prog("edge_lowto", 1, 2, 16, 0, '0);
        run_prog("edge_busyto", 1, 16, 2, 0, '0);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < DEPTH; i++) begin
                w = 9'($urandom);
                w[8] = ($urandom_range(0, 11) == 0);
                load(i, w);
            end
            len = (t % 5 == 0) ? DEPTH : int'($urandom_range(0, DEPTH));
            run_prog($sformatf("rand%0d", t), len, int'($urandom_range(0, 4)),
                     int'($urandom_range(1, 5)), 0, '0);
        end

        // Reset while the processor is executing
        for (int i = 0; i < DEPTH; i++) load(i, 9'b000010001);
        p_drop = 1; p_low = 10;
        @(negedge Clock);
        ProgLen = (ADDR_W+1)'(DEPTH);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge Clock);
            if (Done === 1'b0) found = 1;
        end
        check("midrst reached_wait_done", 32'(found), 1);
        @(negedge Clock);
        check("midrst busy_before", 32'(Busy), 1);
        #2 Resetn = 1'b0;
        #1;
        check("midrst din", 32'(DIN), 0);
        check("midrst run", 32'(Run), 0);
        check("midrst pc", 32'(PC), 0);
        check("midrst busy", 32'(Busy), 0);
        check("midrst error", 32'(Error), 0);
        check("midrst halted", 32'(Halted), 0);
        repeat (20) @(negedge Clock);
        Resetn = 1'b1;
        repeat (2) @(negedge Clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Instruction-feed stage directly upstream of the 9-bit processor.
- Holds a small program RAM loaded through a write port.
- On Start, presents each instruction word (iiixxxyyy) on DIN, pulses Run, and waits for the processor's Done.
- Supplies the immediate word for MVI, stops on a HALT opcode, and flags protocol timeouts.

Parameters:
- ADDR_W, 5, program RAM address width; depth is 2**ADDR_W words of 9 bits.
- SETUP_CYC, 2, cycles an instruction is held on DIN with Run=0 before Run is pulsed (covers the processor's registered IR enable).
- TIMEOUT, 15, maximum cycles to wait in WAIT_BUSY or WAIT_DONE before declaring Error.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Resetn  in  1  reset, asynchronous, active-low.
- Start  in  1  single-cycle request to run the program from address 0.
- ProgLen  in  ADDR_W+1  number of valid words; sampled on accepted Start.
- LdEn  in  1  program RAM write enable; honoured only when Busy=0.
- LdAddr  in  ADDR_W  write address.
- LdData  in  9  write data.
- Done  in  1  processor completion flag.
- DIN  out  9  word driven to the processor (registered).
- Run  out  1  processor run strobe (registered).
- PC  out  ADDR_W  address of the current instruction.
- Busy  out  1  high from accepted Start until IDLE, HALT or ERR is reached.
- Halted  out  1  sticky: a HALT opcode was executed or the program end was reached.
- Error  out  1  sticky: timeout or truncated MVI.

Behaviour:
- Reset (async): state IDLE; DIN=0, Run=0, PC=0, Busy=0, Halted=0, Error=0. RAM contents are not reset.
- Reset mid-operation aborts immediately to these values.
- RAM: synchronous write on LdEn & !Busy. LdEn while Busy is ignored. Read is synchronous; DIN registers the RAM output.
- Start accepted only in IDLE, HALT or ERR. Acceptance clears Halted and Error, sets PC=0 and Busy=1, latches ProgLen, and goes to CHECK. Start while Busy is ignored.
- CHECK: if PC >= latched ProgLen (including ProgLen=0), go to HALT. Otherwise load DIN=mem[PC], Run=0, and go to SETUP.
- SETUP: hold DIN for SETUP_CYC cycles with Run=0, then go to ISSUE.
- Opcode decode on DIN[8:6]:
  - 1xx is HALT: no Run pulse; go to HALT.
  - 001 (MVI) with PC+1 >= ProgLen: go to ERR.
- ISSUE: Run=1 for exactly 1 cycle.
  - For MVI, DIN switches to mem[PC+1] in the cycle after the Run pulse.
  - Otherwise DIN is unchanged.
  - Go to WAIT_BUSY.
- WAIT_BUSY: wait for Done=0.
- WAIT_DONE: wait for Done=1.
- Timeout counter: reset on entry to each wait state. If it reaches TIMEOUT with no transition, go to ERR.
- HOLD: after Done=1 is seen, keep DIN stable 1 more cycle, then advance.
  - PC += 2 for MVI, PC += 1 otherwise.
  - Return to CHECK.
- Opcodes 000, 010 and 011 are single-word.
- PC is ADDR_W bits. Sum computation is ADDR_W+1 bits so that the comparison against ProgLen never wraps.
- HALT: Busy=0, Halted=1, Run=0; DIN holds its last value.
- ERR: Busy=0, Error=1, Run=0.
- Run is never high in any state other than ISSUE.
- Start and LdEn in the same cycle while idle: both take effect. The write lands, and the CHECK read in the next cycle sees the new data.

Test Plan:
- Reset → idle outputs:
  - Stimulus: assert Resetn=0 mid-WAIT_DONE.
  - Required: DIN=0, Run=0, PC=0, Busy=0, Error=0 within the same cycle.
- Simple program:
  - Stimulus: load 001000000, 000000101, 000001000, 100000000 (MVI R0,#5; MV R1,R0; HALT); ProgLen=4; Start; processor model drops Done 1 cycle after Run and raises it 1 cycle later.
  - Required:
    - Exactly two Run pulses.
    - DIN=000000101 after the first pulse.
    - PC sequence 0, 2, 3.
    - Ends with Halted=1, Busy=0.
- ADD/SUB pacing:
  - Stimulus: program 010000001, 011000001; ProgLen=2; processor holds Done=0 for 3 cycles each.
  - Required: 2 Run pulses, each ≥SETUP_CYC+HOLD spacing from the previous Done rise; Halted=1 at PC=2.
- Timeout:
  - Stimulus: Done stuck at 1 after the Run pulse.
  - Required: Error=1, Busy=0 after exactly TIMEOUT=15 cycles in WAIT_BUSY; no further Run.
- Truncated MVI:
  - Stimulus: ProgLen=1 with mem[0]=001011000.
  - Required: no Run pulse; Error=1.
- Load protection:
  - Stimulus: LdEn with LdAddr=0, LdData=111111111 while Busy.
  - Required: mem[0] unchanged on rerun.
- ProgLen=0:
  - Stimulus: Start with ProgLen=0.
  - Required: Halted=1, no Run.
